// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the register-file write arbiter.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    // Register 0 reads as zero; writes to it are accepted but never enabled.
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side bus of the register-file write arbiter: packed per-requester
// valid/last/addr/data towards the arbiter and a one-hot ready back.
interface regfile_wr_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    import cpu_pkg::*;

    // A beat transfers on a rising clk edge where req_valid[i] && req_ready[i].
    // Once req_valid[i] is high, requester i holds addr/data/last until that edge.
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_last,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_last,
        input  req_addr,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Combinational round-robin select: first valid requester after last_gnt,
// wrapping N-1 -> 0, returned as a one-hot grant and an index.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] last_gnt,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] winner
);

    int   idx;
    logic found;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        // Explicit wrap keeps the search in range for non-power-of-two N.
        for (int k = 1; k <= N; k++) begin
            idx = int'(last_gnt) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                winner      = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register bank write port between NUM_REQ
// writeback requesters, with a short locked burst for rd/rd+1 pairs.
module regfile_wr_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    regfile_wr_arbiter_if.slave  req,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 busy,
    output arb_state_t           dbg_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_t         state, state_n;
    logic [IDX_W-1:0]   owner, owner_n;
    logic [IDX_W-1:0]   last_gnt, last_gnt_n;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_n;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] ready;
    logic [IDX_W-1:0]   sel;
    logic               accept;

    logic [ADDR_W-1:0]  addr_a [NUM_REQ];
    logic [DATA_W-1:0]  data_a [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_a[i] = req.req_addr[i*ADDR_W +: ADDR_W];
        assign data_a[i] = req.req_data[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid    (req.req_valid),
        .last_gnt (last_gnt),
        .grant    (pick_grant),
        .winner   (pick_idx)
    );

    always_comb begin
        ready      = '0;
        sel        = pick_idx;
        accept     = 1'b0;
        state_n    = state;
        owner_n    = owner;
        last_gnt_n = last_gnt;
        beat_cnt_n = beat_cnt;

        if (rst_n && !stall) begin
            case (state)
                IDLE: ready = pick_grant;
                LOCK: begin
                    // Owner keeps the port through gap cycles; others wait.
                    sel          = owner;
                    ready[owner] = req.req_valid[owner];
                end
                default: ready = '0;
            endcase
        end
        accept = |ready;

        if (accept) begin
            case (state)
                IDLE: begin
                    last_gnt_n = sel;
                    if (!req.req_last[sel] && (MAX_BURST > 1)) begin
                        state_n    = LOCK;
                        owner_n    = sel;
                        beat_cnt_n = CNT_W'(1);
                    end
                end
                LOCK: begin
                    if (req.req_last[sel] || (int'(beat_cnt) + 1 >= MAX_BURST)) begin
                        state_n    = IDLE;
                        beat_cnt_n = '0;
                    end else begin
                        beat_cnt_n = beat_cnt + CNT_W'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign req.req_ready = ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            last_gnt <= IDX_W'(NUM_REQ - 1);
            beat_cnt <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            last_gnt <= last_gnt_n;
            beat_cnt <= beat_cnt_n;
            wr_en    <= accept && (addr_a[sel] != ZERO_REG);
            if (accept) begin
                wr_addr <= addr_a[sel];
                wr_data <= data_a[sel];
            end
        end
    end

    assign busy      = (state == LOCK);
    assign dbg_state = state;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: per-cycle ready/wr_en/busy vectors,
// a write scoreboard and a requester-stability monitor.
module tb_regfile_wr_arbiter;
    import cpu_pkg::*;

    localparam int NR = 4;
    localparam int W  = ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stall;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    arb_state_t        dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.NUM_REQ(NR)) rif ();

    regfile_wr_arbiter #(
        .NUM_REQ   (NR),
        .MAX_BURST (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .req       (rif),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic l,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        rif.req_valid[i]               = v;
        rif.req_last[i]                = l;
        rif.req_addr[i*ADDR_W +: ADDR_W] = a;
        rif.req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic chk_cycle(input string tag, input logic [NR-1:0] rdy,
                             input logic we, input logic bsy);
        @(negedge clk);
        check({tag, "_ready"}, 32'(rif.req_ready), 32'(rdy));
        check({tag, "_wr_en"}, 32'(wr_en), 32'(we));
        check({tag, "_busy"},  32'(busy), 32'(bsy));
    endtask

    // scoreboard and requester-stability monitor
    logic [NR-1:0]     pv = '0;
    logic [NR-1:0]     pr = '0;
    logic [W:0]        pbeat [NR];
    logic              prst = 1'b0;

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (wr_en === 1'b1) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            check("sb_wr", 32'({wr_addr, wr_data}), 32'(e));
        end
        if (prst && rst_n) begin
            for (int i = 0; i < NR; i++) begin
                if (pv[i] && !pr[i] && rif.req_valid[i]) begin
                    check("req_stable",
                          32'({rif.req_last[i], rif.req_addr[i*ADDR_W +: ADDR_W],
                               rif.req_data[i*DATA_W +: DATA_W]}),
                          32'(pbeat[i]));
                end
            end
        end
        for (int i = 0; i < NR; i++) begin
            pbeat[i] = {rif.req_last[i], rif.req_addr[i*ADDR_W +: ADDR_W],
                        rif.req_data[i*DATA_W +: DATA_W]};
        end
        pv   = rif.req_valid;
        pr   = rif.req_ready;
        prst = rst_n;
    end

    initial begin
        logic [NR-1:0] r;
        rst_n = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, ADDR_W'(i + 1), DATA_W'(16'hA000 + i));

        // reset with all requesters valid
        step();
        @(negedge clk);
        check("rst_ready",   32'(rif.req_ready), 32'h0);
        check("rst_wr_en",   32'(wr_en), 32'h0);
        check("rst_wr_addr", 32'(wr_addr), 32'h0);
        check("rst_wr_data", 32'(wr_data), 32'h0);
        check("rst_busy",    32'(busy), 32'h0);
        check("rst_state",   32'(dbg_state), 32'(IDLE));
        step();
        chk_cycle("rst2", 4'b0000, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;

        // round robin, single beats
        for (int k = 0; k < 8; k++) begin
            r = NR'(1 << (k % 4));
            chk_cycle("rr", r, k != 0, 1'b0);
            expect_wr(ADDR_W'(k % 4 + 1), DATA_W'(16'hA000 + k % 4));
            step();
        end
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b1, ADDR_W'(i + 1), DATA_W'(16'hA000 + i));
        chk_cycle("rr_drain", 4'b0000, 1'b1, 1'b0);
        step();

        // locked burst with a valid gap; req2 waits
        set_req(1, 1'b1, 1'b0, 3'd2, 16'hB100);
        set_req(2, 1'b1, 1'b1, 3'd5, 16'hC002);
        chk_cycle("lk_beat1", 4'b0010, 1'b0, 1'b0);
        expect_wr(3'd2, 16'hB100);
        step();
        set_req(1, 1'b0, 1'b1, 3'd3, 16'hB101);
        chk_cycle("lk_gap", 4'b0000, 1'b1, 1'b1);
        step();
        set_req(1, 1'b1, 1'b1, 3'd3, 16'hB101);
        chk_cycle("lk_beat2", 4'b0010, 1'b0, 1'b1);
        expect_wr(3'd3, 16'hB101);
        step();
        set_req(1, 1'b0, 1'b1, 3'd3, 16'hB101);
        chk_cycle("lk_release", 4'b0100, 1'b1, 1'b0);
        expect_wr(3'd5, 16'hC002);
        step();
        set_req(2, 1'b0, 1'b1, 3'd5, 16'hC002);
        chk_cycle("lk_idle", 4'b0000, 1'b1, 1'b0);
        step();

        // forced release after MAX_BURST beats
        set_req(0, 1'b1, 1'b0, 3'd4, 16'hD000);
        chk_cycle("fr_beat1", 4'b0001, 1'b0, 1'b0);
        expect_wr(3'd4, 16'hD000);
        step();
        set_req(0, 1'b1, 1'b0, 3'd5, 16'hD001);
        set_req(3, 1'b1, 1'b1, 3'd7, 16'hD003);
        chk_cycle("fr_beat2", 4'b0001, 1'b1, 1'b1);
        expect_wr(3'd5, 16'hD001);
        step();
        set_req(0, 1'b1, 1'b0, 3'd6, 16'hD002);
        chk_cycle("fr_other", 4'b1000, 1'b1, 1'b0);
        expect_wr(3'd7, 16'hD003);
        step();
        set_req(3, 1'b0, 1'b1, 3'd7, 16'hD003);
        chk_cycle("fr_beat3", 4'b0001, 1'b1, 1'b0);
        expect_wr(3'd6, 16'hD002);
        step();
        set_req(0, 1'b1, 1'b1, 3'd1, 16'hD004);
        chk_cycle("fr_close", 4'b0001, 1'b1, 1'b1);
        expect_wr(3'd1, 16'hD004);
        step();
        set_req(0, 1'b0, 1'b1, 3'd1, 16'hD004);
        chk_cycle("fr_idle", 4'b0000, 1'b1, 1'b0);
        step();

        // stall, then zero-register write
        stall = 1'b1;
        set_req(2, 1'b1, 1'b1, 3'd3, 16'hE002);
        for (int k = 0; k < 3; k++) begin
            chk_cycle("st_hold", 4'b0000, 1'b0, 1'b0);
            step();
        end
        stall = 1'b0;
        chk_cycle("st_release", 4'b0100, 1'b0, 1'b0);
        expect_wr(3'd3, 16'hE002);
        step();
        set_req(2, 1'b1, 1'b1, 3'd0, 16'hFFFF);
        chk_cycle("zr_beat", 4'b0100, 1'b1, 1'b0);
        step();
        set_req(2, 1'b0, 1'b1, 3'd0, 16'hFFFF);
        chk_cycle("zr_after", 4'b0000, 1'b0, 1'b0);
        check("zr_wr_addr", 32'(wr_addr), 32'h0);
        check("zr_wr_data", 32'(wr_data), 32'hFFFF);
        step();

        // reset in the middle of a burst
        set_req(3, 1'b1, 1'b0, 3'd2, 16'hF003);
        chk_cycle("mb_beat1", 4'b1000, 1'b0, 1'b0);
        expect_wr(3'd2, 16'hF003);
        step();
        set_req(3, 1'b1, 1'b1, 3'd3, 16'hF013);
        rst_n = 1'b0;
        chk_cycle("mb_rst", 4'b0000, 1'b1, 1'b1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, ADDR_W'(i + 1), DATA_W'(16'hA000 + i));
        chk_cycle("mb_after", 4'b0001, 1'b0, 1'b0);
        check("mb_state",   32'(dbg_state), 32'(IDLE));
        check("mb_wr_addr", 32'(wr_addr), 32'h0);
        check("mb_wr_data", 32'(wr_data), 32'h0);
        expect_wr(3'd1, 16'hA000);
        step();
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b1, ADDR_W'(i + 1), DATA_W'(16'hA000 + i));
        chk_cycle("mb_done", 4'b0000, 1'b1, 1'b0);
        step();
        chk_cycle("end_idle", 4'b0000, 1'b0, 1'b0);

        // final report
        check("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single write port of the 8 x 16-bit register bank between NUM_REQ writeback requesters: ALU, load unit, multiply unit and the debug port.
- Each requester uses a valid/ready handshake to the arbiter.
- Fair round-robin arbitration with a short locked burst, so a 32-bit result written as rd/rd+1 is never split by another requester.
- Drives registered wr_en/wr_addr/wr_data into the flip-flop register bank.

Parameters:
NUM_REQ, 4, number of requesters
DATA_W, 16, register width
ADDR_W, 3, register address width (8 registers)
MAX_BURST, 2, maximum beats held under one lock

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
stall  in  1  pipeline stall; no grant while high
req_valid  in  NUM_REQ  per-requester write request
req_last  in  NUM_REQ  beat is last of burst (single writes tie high)
req_addr  in  NUM_REQ*ADDR_W  packed target register, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed write data, same packing
req_ready  out  NUM_REQ  one-hot grant; beat transfers when valid && ready
wr_en  out  1  register bank write enable (registered)
wr_addr  out  ADDR_W  register bank write address (registered)
wr_data  out  DATA_W  register bank write data (registered)
busy  out  1  high while in state LOCK

Behaviour:
- Reset is synchronous and active-low (rst_n, sampled on posedge clk).
  - Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, state=IDLE, beat count=0.
  - Round-robin pointer last_gnt=NUM_REQ-1, so requester 0 has top priority first.
  - req_ready is all-zero combinationally while rst_n=0.
- req_ready is combinational from state, pointer, stall and req_valid. It is at most one-hot and never asserted to a requester whose valid is low.
- Latency: a beat accepted in cycle N appears on wr_en/wr_addr/wr_data in cycle N+1. wr_en is high for exactly one cycle per accepted beat.
- States: IDLE, LOCK. The beat counter is 0..MAX_BURST-1.
- IDLE:
  - Winner is the first valid requester searching from last_gnt+1 upward, wrapping NUM_REQ-1 -> 0.
  - On accept, last_gnt <= winner.
  - If req_last=0 and MAX_BURST>1: go to LOCK with owner=winner and beat count=1.
  - Otherwise stay in IDLE.
- LOCK:
  - Only the owner may be granted. Other requesters wait even when owner valid is low (gap cycles allowed).
  - Each accepted beat increments the beat count.
  - Return to IDLE after a beat with req_last=1, or when that beat brings the count to MAX_BURST (forced release).
  - last_gnt stays at owner.
- stall=1: req_ready all-zero. State, pointer and count are held. wr_en is 0 in the next cycle.
- Address 0 (hardwired zero register):
  - The beat is accepted and counts toward burst and arbitration.
  - wr_en stays 0 for it; wr_addr/wr_data still update.
- No wr_en cycle: wr_addr/wr_data hold their previous values.
- Requester obligation: once valid is high, addr/data/last stay stable until accepted. The bench asserts this; the RTL does not check it.
- Reset mid-burst: returns to IDLE; the pending beat is dropped (requester must re-present it); wr_en=0 next cycle.
- Out-of-range requester index is impossible by construction. The pointer is a clog2(NUM_REQ)-bit register wrapped explicitly for non-power-of-two NUM_REQ.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W and ADDR_W constants
  - state enum typedef arb_state_t {IDLE, LOCK}
  - ZERO_REG address constant
- One sub-module, rr_pick: combinational round-robin select taking (valid vector, last_gnt) and returning a one-hot grant plus winner index. It is reusable by the memory-port arbiter.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all valid=1 -> req_ready=0000, wr_en=0, wr_addr=0, wr_data=0, busy=0. First cycle after release grants req0 (ready=0001).
- Round robin: all four valid, single beats, addr=i+1, data=16'hA000+i, held 8 cycles -> grant order 0,1,2,3,0,1,2,3. wr_en each cycle from N+1 with wr_addr 1,2,3,4 and wr_data A000..A003.
- Locked burst:
  - req1 presents addr 2 (last=0), then after a 1-cycle valid gap presents addr 3 (last=1); req2 valid throughout.
  - Expected: busy=1 from after beat 1 until after beat 2. req2 is not granted during the gap. req2 is granted the cycle after busy falls.
- Forced release: req0 keeps last=0 for 3 beats -> after 2 beats state returns to IDLE. req3 (valid) is granted before req0's third beat.
- Stall and zero register:
  - stall=1 for 3 cycles with req2 valid -> ready=0000, wr_en=0 for those cycles. req2 is granted on the first cycle stall=0.
  - req2 then writes addr 0, data 16'hFFFF -> ready pulses, wr_en stays 0.
- Reset mid-burst: req3 beat 1 (last=0) accepted, then rst_n=0 for 1 cycle -> state IDLE, busy=0, wr_en=0. After reset, with all valid, req0 is granted first.
